bit_slice: RTL and testbench

One-bit ALU slice for the 32-bit ALU of the multi-cycle CPU; 32 instances are chained through the carry to form the datapath ALU. Each cycle it computes AND, NAND, OR, NOR and XOR of its operand bits. It also computes one full-adder sum shared by ADD, SUB and SLT, plus carry-out. All results are registered on the rising clock edge.

---
 rtl/bit_slice.sv | 134 +++++++++++++
 tb/tb_bit_slice.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bit_slice.sv
// -----------------------------------------------------------------------------
// bit_slice
//
// Purpose:
//   One-bit ALU slice for the multi-cycle CPU datapath. It computes AND, NAND,
//   OR, NOR and XOR of the raw operand bits, and one full-adder sum and
//   carry-out. ADD, SUB and SLT all use that same sum. Every result is
//   registered, so the latency from inputs to outputs is exactly one clock.
//   Thirty-two of these slices are chained through cin/cout by the enclosing
//   ALU.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high; clears every output flop to 0
//   A, B   in   operand bits
//   cin    in   carry from the next-lower slice (or the LSB carry source)
//   ctl1   in   carry enable (1 passes cin into the adder)
//   ctl2   in   B invert for the adder (1 selects ~B)
//   oAnd, oNand, oOr, oNor, oXor   out  registered logic results of raw A/B
//   oAdd, oSub, oSLT               out  registered adder sum (identical values)
//   cout                           out  registered adder carry-out
//   oOvf                           out  registered ce ^ co (only with macro)
//
// Configuration:
//   BITSLICE_OVF_EN  when defined, adds the oOvf output and its flop.
// -----------------------------------------------------------------------------
module bit_slice (
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic cin,
    input  logic ctl1,
    input  logic ctl2,
    output logic oAnd,
    output logic oNand,
    output logic oOr,
    output logic oNor,
    output logic oXor,
    output logic oAdd,
    output logic oSub,
    output logic oSLT,
    output logic cout
`ifdef BITSLICE_OVF_EN
    ,
    output logic oOvf
`endif
);

    // Adder operands
    logic bx;       // B after the optional inversion
    logic ce;       // carry actually admitted into the adder
    logic sum;
    logic carry;

    // Next-state values
    logic and_d,  nand_d, or_d,  nor_d, xor_d;
    logic sum_d,  cout_d;

    // Registered state
    logic and_q,  nand_q, or_q,  nor_q, xor_q;
    logic sum_q,  cout_q;

    always_comb begin
        bx    = B ^ ctl2;
        ce    = cin & ctl1;
        sum   = A ^ bx ^ ce;
        carry = (A & bx) | (A & ce) | (bx & ce);

        // The logic results use the raw operands; ctl1/ctl2/cin never affect them.
        and_d  = A & B;
        nand_d = ~(A & B);
        or_d   = A | B;
        nor_d  = ~(A | B);
        xor_d  = A ^ B;
        sum_d  = sum;
        cout_d = carry;
    end

    // Reset forces every flop to 0, including NAND/NOR, whose logic value
    // for A=B=0 would be 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            and_q  <= 1'b0;
            nand_q <= 1'b0;
            or_q   <= 1'b0;
            nor_q  <= 1'b0;
            xor_q  <= 1'b0;
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            and_q  <= and_d;
            nand_q <= nand_d;
            or_q   <= or_d;
            nor_q  <= nor_d;
            xor_q  <= xor_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign oAnd  = and_q;
    assign oNand = nand_q;
    assign oOr   = or_q;
    assign oNor  = nor_q;
    assign oXor  = xor_q;
    // ADD, SUB and SLT share one sum flop. The MSB slice's sum is the SLT sign.
    assign oAdd  = sum_q;
    assign oSub  = sum_q;
    assign oSLT  = sum_q;
    assign cout  = cout_q;

`ifdef BITSLICE_OVF_EN
    // Carry-in XOR carry-out of this slice. On the MSB slice this is the
    // signed overflow flag.
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_d = ce ^ carry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign oOvf = ovf_q;
`endif

endmodule

// File: tb/tb_bit_slice.sv
// -----------------------------------------------------------------------------
// tb_bit_slice
//
// Directed testbench for bit_slice. The expected values are hand-computed
// constant tables indexed by the input pattern. The bench covers:
//   - asynchronous reset
//   - the ADD, SUB/SLT, logic and {ctl2,ctl1}=10 modes
//   - one-cycle latency
//   - the overflow flag, when BITSLICE_OVF_EN is defined
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bit_slice;

    logic clk;
    logic reset;
    logic A, B, cin, ctl1, ctl2;
    logic oAnd, oNand, oOr, oNor, oXor, oAdd, oSub, oSLT, cout;
`ifdef BITSLICE_OVF_EN
    logic oOvf;
`endif

    int tests_run;
    int tests_failed;

    bit_slice dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .ctl1  (ctl1),
        .ctl2  (ctl2),
        .oAnd  (oAnd),
        .oNand (oNand),
        .oOr   (oOr),
        .oNor  (oNor),
        .oXor  (oXor),
        .oAdd  (oAdd),
        .oSub  (oSub),
        .oSLT  (oSLT),
        .cout  (cout)
`ifdef BITSLICE_OVF_EN
        ,
        .oOvf  (oOvf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %b", tag, got);
        end
    endtask

    // Drive on the falling edge, let one rising edge capture the inputs,
    // then sample 1 ns after that edge.
    task automatic apply(input logic a, input logic b, input logic c,
                         input logic c2, input logic c1);
        @(negedge clk);
        A = a; B = b; cin = c; ctl2 = c2; ctl1 = c1;
        @(posedge clk);
        #1;
    endtask

    // Expected tables. Bit i of each vector is the result for pattern i.
    // The 8-bit tables use i = {A,B,cin}; the 4-bit tables use i = {A,B}.
    logic [7:0] add_sum_v;
    logic [7:0] add_co_v;
    logic [7:0] sub_sum_v;
    logic [7:0] sub_co_v;
    logic [3:0] xor_v;
    logic [3:0] nand_v;
    logic [3:0] and_v;
    logic [3:0] nor_v;
    logic [3:0] or_v;
    logic [3:0] lco_v;

    initial begin
        add_sum_v = 8'b1001_0110;
        add_co_v  = 8'b1110_1000;
        sub_sum_v = 8'b0110_1001;
        sub_co_v  = 8'b1011_0010;
        xor_v     = 4'b0110;
        nand_v    = 4'b0111;
        and_v     = 4'b1000;
        nor_v     = 4'b0001;
        or_v      = 4'b1110;
        lco_v     = 4'b1000;
        tests_run    = 0;
        tests_failed = 0;

        reset = 1'b1;
        A = 1'b1; B = 1'b1; cin = 1'b0; ctl1 = 1'b0; ctl2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Assert reset mid-cycle: the outputs must clear with no clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_bit("rst_and",  oAnd,  1'b0);
        check_bit("rst_nand", oNand, 1'b0);
        check_bit("rst_or",   oOr,   1'b0);
        check_bit("rst_nor",  oNor,  1'b0);
        check_bit("rst_xor",  oXor,  1'b0);
        check_bit("rst_add",  oAdd,  1'b0);
        check_bit("rst_cout", cout,  1'b0);
`ifdef BITSLICE_OVF_EN
        check_bit("rst_ovf",  oOvf,  1'b0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_bit("post_rst_and",  oAnd,  1'b1);
        check_bit("post_rst_nand", oNand, 1'b0);
        check_bit("post_rst_or",   oOr,   1'b1);
        check_bit("post_rst_nor",  oNor,  1'b0);
        check_bit("post_rst_xor",  oXor,  1'b0);

        // ADD sweep, {ctl2,ctl1}=01
        for (int i = 0; i < 8; i++) begin
            logic [2:0] p;
            p = 3'(i);
            apply(p[2], p[1], p[0], 1'b0, 1'b1);
            check_bit($sformatf("add_sum[%0d]", i),  oAdd, add_sum_v[i]);
            check_bit($sformatf("add_sub[%0d]", i),  oSub, add_sum_v[i]);
            check_bit($sformatf("add_slt[%0d]", i),  oSLT, add_sum_v[i]);
            check_bit($sformatf("add_cout[%0d]", i), cout, add_co_v[i]);
        end

        // SUB/SLT sweep, {ctl2,ctl1}=11
        for (int i = 0; i < 8; i++) begin
            logic [2:0] p;
            p = 3'(i);
            apply(p[2], p[1], p[0], 1'b1, 1'b1);
            check_bit($sformatf("sub_sub[%0d]", i),  oSub, sub_sum_v[i]);
            check_bit($sformatf("sub_slt[%0d]", i),  oSLT, sub_sum_v[i]);
            check_bit($sformatf("sub_cout[%0d]", i), cout, sub_co_v[i]);
        end

        // Logic mode, {ctl2,ctl1}=00, with cin=1 (it must be blocked)
        for (int j = 0; j < 4; j++) begin
            logic [1:0] p;
            p = 2'(j);
            apply(p[1], p[0], 1'b1, 1'b0, 1'b0);
            check_bit($sformatf("log_xor[%0d]", j),  oXor,  xor_v[j]);
            check_bit($sformatf("log_nand[%0d]", j), oNand, nand_v[j]);
            check_bit($sformatf("log_and[%0d]", j),  oAnd,  and_v[j]);
            check_bit($sformatf("log_nor[%0d]", j),  oNor,  nor_v[j]);
            check_bit($sformatf("log_or[%0d]", j),   oOr,   or_v[j]);
            check_bit($sformatf("log_cout[%0d]", j), cout,  lco_v[j]);
        end

        // {ctl2,ctl1}=10: s = A^~B, co = A&~B, and cin is ignored
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_bit("m10_sum_a1b0", oAdd, 1'b0);
        check_bit("m10_co_a1b0",  cout, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_bit("m10_sum_a0b0", oAdd, 1'b1);
        check_bit("m10_co_a0b0",  cout, 1'b0);

        // Latency: A changes 0->1 mid-cycle; the outputs hold until the next edge.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_bit("lat_before_sum", oAdd, 1'b1);
        check_bit("lat_before_co",  cout, 1'b0);
        @(negedge clk);
        A = 1'b1;
        #1;
        check_bit("lat_hold_sum", oAdd, 1'b1);
        check_bit("lat_hold_co",  cout, 1'b0);
        @(posedge clk);
        #1;
        check_bit("lat_after_sum", oAdd, 1'b0);
        check_bit("lat_after_co",  cout, 1'b1);

`ifdef BITSLICE_OVF_EN
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_bit("ovf_001", oOvf, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_bit("ovf_110", oOvf, 1'b1);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_bit("ovf_101", oOvf, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
